// File: rtl/dcache_mem_pkg.sv
// Shared types for the data-cache memory responder: request/response
// bundles, responder FSM states and the SRAM word size.
package dcache_mem_pkg;

    localparam int WORD_BYTES = 8;
    localparam int TID_W      = 2;
    localparam int ADDR_W     = 32;
    localparam int LINE_W     = 128;

    typedef struct packed {
        logic              we;
        logic [TID_W-1:0]  tid;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       wdata;
        logic [7:0]        be;
    } mem_req_t;

    typedef struct packed {
        logic [TID_W-1:0]  tid;
        logic              we;
        logic              err;
        logic [LINE_W-1:0] rdata;
    } mem_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_W1  = 2'd1,
        ST_RD_CAP = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/dcache_mem_req_fifo.sv
// Synchronous request FIFO with full/empty flags; push and pop may
// happen in the same cycle. Ports: push_i/din_i, pop_i/dout_o, full_o, empty_o.
module dcache_mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (r_cnt == CW'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign dout_o  = r_mem[r_rd];

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= din_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= inc(r_wr);
            if (w_pop)  r_rd <= inc(r_rd);
            if (w_push & ~w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (~w_push & w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder: buffers cache requests, services them on a
// 1-cycle-latency 64-bit SRAM and returns one in-order TID-tagged response
// each. Ports: req_* (cache request), rsp_* (response), sram_* (SRAM port).
module dcache_mem_responder
    import dcache_mem_pkg::*;
#(
    parameter int TID_WIDTH   = TID_W,
    parameter int ADDR_WIDTH  = ADDR_W,
    parameter int LINE_WIDTH  = LINE_W,
    parameter int DEPTH_WORDS = 1024,
    parameter int REQ_DEPTH   = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_we_i,
    input  logic [TID_WIDTH-1:0]           req_tid_i,
    input  logic [ADDR_WIDTH-1:0]          req_addr_i,
    input  logic [63:0]                    req_wdata_i,
    input  logic [7:0]                     req_be_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [TID_WIDTH-1:0]           rsp_tid_o,
    output logic                           rsp_we_o,
    output logic                           rsp_err_o,
    output logic [LINE_WIDTH-1:0]          rsp_rdata_o,
    output logic                           sram_req_o,
    output logic                           sram_we_o,
    output logic [$clog2(DEPTH_WORDS)-1:0] sram_addr_o,
    output logic [63:0]                    sram_wdata_o,
    output logic [7:0]                     sram_be_o,
    input  logic [63:0]                    sram_rdata_i
);

    localparam int OFS = $clog2(WORD_BYTES);
    localparam int IW  = ADDR_WIDTH - OFS;
    localparam int AW  = $clog2(DEPTH_WORDS);

    mem_req_t      w_in;
    mem_req_t      w_head;
    mem_rsp_t      r_rsp;
    rsp_state_e    r_state;
    rsp_state_e    w_next;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_dispatch;
    logic          w_rsp_free;
    logic          w_err;
    logic          w_ld_imm;
    logic          w_ld_line;
    logic          r_rsp_valid;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_last_idx;
    logic [AW-2:0] r_line;
    logic [TID_WIDTH-1:0] r_tid;
    logic [63:0]   r_lo;
    logic          w_unused;

    assign w_in = '{we: req_we_i, tid: req_tid_i, addr: req_addr_i,
                    wdata: req_wdata_i, be: req_be_i};

    assign req_ready_o = ~w_full;
    assign w_push      = req_valid_i & ~w_full;

    dcache_mem_req_fifo #(
        .WIDTH ($bits(mem_req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .din_i   (w_in),
        .pop_i   (w_dispatch),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // A read touches the odd word of its line last, so range-check that one.
    assign w_idx      = w_head.addr[ADDR_WIDTH-1:OFS];
    assign w_last_idx = w_head.we ? w_idx : {w_idx[IW-1:1], 1'b1};
    assign w_err      = (w_last_idx >= IW'(DEPTH_WORDS));
    assign w_unused   = ^w_head.addr[OFS-1:0];

    assign w_rsp_free = ~r_rsp_valid | rsp_ready_i;
    assign w_dispatch = ~w_empty & (r_state == ST_IDLE) & w_rsp_free;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_dispatch & ~w_err & ~w_head.we) w_next = ST_RD_W1;
            ST_RD_W1:  w_next = ST_RD_CAP;
            ST_RD_CAP: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        w_ld_imm     = 1'b0;
        w_ld_line    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_dispatch) begin
                    w_ld_imm = w_err | w_head.we;
                    if (~w_err) begin
                        sram_req_o = 1'b1;
                        sram_we_o  = w_head.we;
                        if (w_head.we) begin
                            sram_addr_o  = w_idx[AW-1:0];
                            sram_wdata_o = w_head.wdata;
                            sram_be_o    = w_head.be;
                        end else begin
                            sram_addr_o = {w_idx[AW-1:1], 1'b0};
                        end
                    end
                end
            end
            ST_RD_W1: begin
                sram_req_o  = 1'b1;
                sram_addr_o = {r_line, 1'b1};
            end
            ST_RD_CAP: w_ld_line = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_line <= '0;
            r_tid  <= '0;
            r_lo   <= '0;
        end else begin
            if (w_dispatch) begin
                r_line <= w_idx[AW-1:1];
                r_tid  <= w_head.tid;
            end
            if (r_state == ST_RD_W1) r_lo <= sram_rdata_i;
        end
    end

    // Loads only happen when the register is empty or draining this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else if (w_ld_imm) begin
            r_rsp_valid <= 1'b1;
            r_rsp       <= '{tid: w_head.tid, we: w_head.we,
                             err: w_err, rdata: '0};
        end else if (w_ld_line) begin
            r_rsp_valid <= 1'b1;
            r_rsp       <= '{tid: r_tid, we: 1'b0, err: 1'b0,
                             rdata: {sram_rdata_i, r_lo}};
        end else if (r_rsp_valid & rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_tid_o   = r_rsp.tid;
    assign rsp_we_o    = r_rsp.we;
    assign rsp_err_o   = r_rsp.err;
    assign rsp_rdata_o = r_rsp.rdata;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Scoreboard bench for dcache_mem_responder: directed cases plus random
// traffic against an in-order behavioural memory model.
module tb_dcache_mem_responder;

    localparam int DW = 1024;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic         req_we_i;
    logic [1:0]   req_tid_i;
    logic [31:0]  req_addr_i;
    logic [63:0]  req_wdata_i;
    logic [7:0]   req_be_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [1:0]   rsp_tid_o;
    logic         rsp_we_o;
    logic         rsp_err_o;
    logic [127:0] rsp_rdata_o;
    logic         sram_req_o;
    logic         sram_we_o;
    logic [9:0]   sram_addr_o;
    logic [63:0]  sram_wdata_o;
    logic [7:0]   sram_be_o;
    logic [63:0]  sram_rdata_i;

    always #5 clk_i = ~clk_i;

    dcache_mem_responder #(
        .TID_WIDTH(2), .ADDR_WIDTH(32), .LINE_WIDTH(128),
        .DEPTH_WORDS(DW), .REQ_DEPTH(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_tid_i(req_tid_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_tid_o(rsp_tid_o), .rsp_we_o(rsp_we_o),
        .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
    );

    typedef struct {
        logic [1:0]   tid;
        logic         we;
        logic         err;
        logic [127:0] rdata;
        int           acc;
        int           lat;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [63:0] sram [DW];
    logic [63:0] refm [DW];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          sram_pulses = 0;
    int          exp_pulses = 0;
    int          addr_log[$];
    logic        held_v = 1'b0;
    logic [4:0]  held_ctl;
    logic [127:0] held_rd;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // SRAM model: byte-enabled write, read data valid the next cycle.
    always @(posedge clk_i) begin
        if (!rst_i && sram_req_o) begin
            sram_pulses++;
            addr_log.push_back(int'(sram_addr_o));
            if (sram_we_o) begin
                for (int b = 0; b < 8; b++)
                    if (sram_be_o[b]) sram[sram_addr_o][8*b +: 8] = sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram[sram_addr_o];
            end
        end
    end

    // Monitor: pop and compare on each handshake; check stalled outputs hold.
    always @(negedge clk_i) begin
        if (rst_i) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("rsp_hold_ctl", 128'({rsp_valid_o, rsp_tid_o, rsp_we_o, rsp_err_o}), 128'(held_ctl));
                chk("rsp_hold_rdata", rsp_rdata_o, held_rd);
            end
            held_v = 1'b0;
            if (rsp_valid_o && rsp_ready_i) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got tid %0d with no request pending", rsp_tid_o);
                end else begin
                    mon_e = q.pop_front();
                    chk("rsp_tid", 128'(rsp_tid_o), 128'(mon_e.tid));
                    chk("rsp_we", 128'(rsp_we_o), 128'(mon_e.we));
                    chk("rsp_err", 128'(rsp_err_o), 128'(mon_e.err));
                    chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
                    if (mon_e.lat >= 0)
                        chk("rsp_latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
                end
            end else if (rsp_valid_o) begin
                held_v   = 1'b1;
                held_ctl = {rsp_valid_o, rsp_tid_o, rsp_we_o, rsp_err_o};
                held_rd  = rsp_rdata_o;
            end
        end
    end

    task automatic send(input logic we, input logic [1:0] tid, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] be, input int lat);
        int n = 0;
        int unsigned idx;
        int unsigned base;
        exp_t e;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_tid_i   = tid;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_be_i    = be;
        do begin
            @(negedge clk_i);
            n++;
        end while (!req_ready_o && n < 500);
        if (!req_ready_o) begin
            n_chk++;
            n_err++;
            $display("FAIL req_accept_timeout: ready=0 after %0d cycles, required 1", n);
            req_valid_i = 1'b0;
            return;
        end
        idx     = int'(addr >> 3);
        e.tid   = tid;
        e.we    = we;
        e.acc   = cyc;
        e.lat   = lat;
        e.rdata = '0;
        if (we) begin
            e.err = (idx >= DW);
            if (!e.err) begin
                for (int b = 0; b < 8; b++)
                    if (be[b]) refm[idx][8*b +: 8] = wd[8*b +: 8];
                exp_pulses += 1;
            end
        end else begin
            base  = idx & ~32'd1;
            e.err = (base + 1 >= DW);
            if (!e.err) begin
                e.rdata = {refm[base + 1], refm[base]};
                exp_pulses += 2;
            end
        end
        q.push_back(e);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        bit done;
        rst_i = 1'b1;
        req_valid_i = 0; req_we_i = 0; req_tid_i = 0; req_addr_i = 0;
        req_wdata_i = 0; req_be_i = 0; rsp_ready_i = 1'b1;
        for (int i = 0; i < DW; i++) begin
            sram[i] = '0;
            refm[i] = '0;
        end
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_rsp_valid", 128'(rsp_valid_o), 0);
        chk("reset_rsp_tid", 128'(rsp_tid_o), 0);
        chk("reset_rsp_we", 128'(rsp_we_o), 0);
        chk("reset_rsp_err", 128'(rsp_err_o), 0);
        chk("reset_rsp_rdata", rsp_rdata_o, 0);
        chk("reset_sram_req", 128'(sram_req_o), 0);
        chk("reset_req_ready", 128'(req_ready_o), 1);
        @(posedge clk_i);
        #1;

        // Write then line read of the same line.
        send(1'b1, 2'd1, 32'h10, 64'hDEADBEEF_CAFEF00D, 8'h0F, 2);
        send(1'b0, 2'd2, 32'h18, 64'h0, 8'h00, 4);
        wait_idle();

        // Back-to-back writes, one response per cycle.
        for (int i = 0; i < 4; i++)
            send(1'b1, 2'(i), 32'h100 + 32'(8 * i), {$urandom, $urandom}, 8'hFF, 2);
        wait_idle();

        // Stalled response path fills the FIFO.
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            send(1'b1, 2'(i), 32'h200 + 32'(8 * i), {$urandom, $urandom}, 8'hFF, -1);
        @(negedge clk_i);
        chk("req_ready_full", 128'(req_ready_o), 0);
        fork
            begin
                send(1'b0, 2'd3, 32'h200, 64'h0, 8'h00, -1);
                send(1'b1, 2'd0, 32'h220, {$urandom, $urandom}, 8'h5A, -1);
            end
            begin
                repeat (8) @(negedge clk_i);
                chk("req_ready_stalled", 128'(req_ready_o), 0);
                chk("rsp_valid_stalled", 128'(rsp_valid_o), 1);
                @(posedge clk_i);
                #1 rsp_ready_i = 1'b1;
            end
        join
        wait_idle();

        // Out-of-range read and write: error response, no SRAM access.
        addr_log.delete();
        send(1'b0, 2'd3, 32'(8 * DW), 64'h0, 8'h00, 2);
        wait_idle();
        send(1'b1, 2'd1, 32'hFFFF_FFF8, 64'h1234, 8'hFF, 2);
        wait_idle();
        chk("err_no_sram", 128'(addr_log.size()), 0);

        // Line read of preloaded words 4/5.
        sram[4] = 64'hAAAA_1111_2222_3333;
        sram[5] = 64'hBBBB_4444_5555_6666;
        refm[4] = 64'hAAAA_1111_2222_3333;
        refm[5] = 64'hBBBB_4444_5555_6666;
        addr_log.delete();
        send(1'b0, 2'd0, 32'h20, 64'h0, 8'h00, 4);
        wait_idle();
        chk("read_sram_count", 128'(addr_log.size()), 2);
        if (addr_log.size() == 2) begin
            chk("read_sram_w0", 128'(addr_log[0]), 4);
            chk("read_sram_w1", 128'(addr_log[1]), 5);
        end
        chk("sram_pulses", 128'(sram_pulses), 128'(exp_pulses));

        // Reset in the middle of a read drops it.
        send(1'b0, 2'd1, 32'h40, 64'h0, 8'h00, -1);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        chk("midreset_rsp_valid", 128'(rsp_valid_o), 0);
        chk("midreset_sram_req", 128'(sram_req_o), 0);
        q.delete();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        sram_pulses = 0;
        exp_pulses  = 0;
        send(1'b1, 2'd2, 32'h48, {$urandom, $urandom}, 8'hFF, 2);
        wait_idle();

        // Random traffic with random response back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(9) == 0)
                        a = 32'(8 * DW) + $urandom_range(0, 4095);
                    else
                        a = $urandom_range(0, 8 * DW - 1);
                    send(1'($urandom_range(1)), 2'($urandom_range(3)), a,
                         {$urandom, $urandom}, 8'($urandom), -1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_i);
                    #1 rsp_ready_i = ($urandom_range(3) != 0);
                end
            end
        join
        rsp_ready_i = 1'b1;
        wait_idle();
        chk("random_sram_pulses", 128'(sram_pulses), 128'(exp_pulses));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
